branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
Closes the loop for the 1-bit branch predictor. It carries each fetched prediction through a shadow IF/ID to ID/EX pipeline and compares it with the actual branch outcome in EX. On a mismatch it issues a redirect and a multi-cycle flush. It also produces the registered EX/MEM update stream (taken bit and target per index) that the predictor consumes, and keeps saturating branch and mispredict counters.

Parameters:
DATA_WIDTH, 32, PC and target width.
IDX_W, 3, predictor index width; index = pc[IDX_W+1:2].
FLUSH_CYCLES, 2, cycles the flush output stays high per mispredict (≥1).
CNT_W, 16, width of the performance counters.

Ports:
i_clk  in  1  clock, rising edge.
i_rst  in  1  synchronous reset, active-high.
i_stall  in  1  pipeline hold; shadow pipeline and resolution frozen.
i_if_valid  in  1  fetch slot holds a real instruction.
i_if_opcode  in  7  fetched opcode; branch when 7'b1100011.
i_if_pc  in  DATA_WIDTH  fetch PC.
i_if_prediction  in  1  predictor taken bit for i_if_pc.
i_if_pred_target  in  DATA_WIDTH  predictor target for i_if_pc.
i_ex_taken  in  1  actual branch outcome from EX comparator.
i_ex_target  in  DATA_WIDTH  actual computed branch target.
o_flush  out  1  zero IF/ID and ID/EX.
o_redirect_valid  out  1  one-cycle PC override.
o_redirect_pc  out  DATA_WIDTH  corrected fetch PC.
o_upd_valid  out  1  predictor write enable (EX/MEM timing).
o_upd_idx  out  IDX_W  predictor entry to write.
o_upd_taken  out  1  taken bit to write.
o_upd_target  out  DATA_WIDTH  target to write.
o_branch_cnt  out  CNT_W  resolved branches, saturating.
o_mispred_cnt  out  CNT_W  mispredicts, saturating.

Behaviour:
- Reset: every output is 0, shadow valid bits are 0, the FSM is in RUN, and both counters are 0. Reset wins over every other input in the same cycle, including mid-FLUSH.
- Shadow pipeline: two stages (ID, EX), each holding {valid, is_branch, pred, pred_target, pc}.
  - When i_stall=0, the stages advance each cycle. The ID stage captures the IF inputs with valid=i_if_valid.
  - When i_stall=1, both stages hold.
- Resolve: occurs in the cycle where the EX stage has valid=1, is_branch=1, i_stall=0, and the FSM is in RUN.
  - mispredict = (i_ex_taken != pred) OR (i_ex_taken AND pred AND i_ex_target != pred_target).
  - A non-taken branch with a stale target is not a mispredict.
- Update (registered, 1 cycle after resolve):
  - o_upd_valid=1, o_upd_idx=pc[IDX_W+1:2], o_upd_taken=i_ex_taken, o_upd_target=i_ex_target.
  - An update is written for every resolved branch, not only for mispredicts.
  - o_upd_valid is 0 in all other cycles.
- Redirect (registered, 1 cycle after a mispredict resolve):
  - o_redirect_valid=1 for exactly 1 cycle.
  - o_redirect_pc = i_ex_target if taken, otherwise pc+4 (mod 2^DATA_WIDTH).
- FSM:
  - RUN -> FLUSH on a mispredict resolve. The flush counter loads FLUSH_CYCLES-1.
  - In FLUSH, o_flush=1 for FLUSH_CYCLES cycles in total, starting in the same cycle as o_redirect_valid.
  - In FLUSH, both shadow valid bits are forced to 0 every cycle (i_stall is ignored) and no resolve occurs.
  - FLUSH -> RUN when the counter reaches 0.
- Counters: o_branch_cnt increments on each resolve and o_mispred_cnt on each mispredict resolve. Both saturate at all-ones with no wrap.
- Non-branch and invalid slots: produce no update, no redirect and no count.
- Back-to-back branches: a branch already in ID when a mispredict resolves is squashed and never resolves. It is re-fetched after the redirect.

Test Plan:
- Correct not-taken: branch at pc=0x10, pred=0, ex_taken=0 -> o_upd_valid pulses with idx=4, taken=0; no flush; branch_cnt=1, mispred_cnt=0.
- Not-taken mispredict: pc=0x20, pred=0, ex_taken=1, target=0x80 -> next cycle redirect_valid=1, redirect_pc=0x80, o_flush high 2 cycles, upd idx=0 taken=1 target=0x80; mispred_cnt=1.
- Taken with wrong target: pc=0x0C, pred=1, pred_target=0x40, ex_target=0x44 -> redirect_pc=0x44, flush 2 cycles; same case with pred_target=0x44 -> no flush.
- Taken mispredict: pc=0xFFFFFFFC, pred=1, ex_taken=0 -> redirect_pc=0x00000000 (wrap), upd taken=0.
- Stall and squash: hold i_stall=1 for 3 cycles with a mispredicting branch in EX -> no resolve until the stall drops. Then a second branch in ID is squashed, and branch_cnt increments only once.
- Reset in FLUSH: assert i_rst in the second flush cycle -> next cycle all outputs and counters are 0 and the FSM is in RUN. Separately, force branch_cnt to all-ones and resolve again -> the count stays at all-ones.

Source files
------------

// File: rtl/branch_resolve_unit_if.sv
// Bundle between the fetch/execute stages, the predictor and the branch resolve unit.
// Latency: none, wires only.
// Backpressure: i_stall is the only hold; there is no valid/ready pair on this bus.
interface branch_resolve_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = 3,
    parameter int CNT_W      = 16
);
    logic                  i_stall;
    logic                  i_if_valid;
    logic [6:0]            i_if_opcode;
    logic [DATA_WIDTH-1:0] i_if_pc;
    logic                  i_if_prediction;
    logic [DATA_WIDTH-1:0] i_if_pred_target;
    logic                  i_ex_taken;
    logic [DATA_WIDTH-1:0] i_ex_target;
    logic                  o_flush;
    logic                  o_redirect_valid;
    logic [DATA_WIDTH-1:0] o_redirect_pc;
    logic                  o_upd_valid;
    logic [IDX_W-1:0]      o_upd_idx;
    logic                  o_upd_taken;
    logic [DATA_WIDTH-1:0] o_upd_target;
    logic [CNT_W-1:0]      o_branch_cnt;
    logic [CNT_W-1:0]      o_mispred_cnt;

    // Pipeline/test side drives the stage inputs and observes the results.
    modport master (
        output i_stall, i_if_valid, i_if_opcode, i_if_pc, i_if_prediction,
               i_if_pred_target, i_ex_taken, i_ex_target,
        input  o_flush, o_redirect_valid, o_redirect_pc, o_upd_valid, o_upd_idx,
               o_upd_taken, o_upd_target, o_branch_cnt, o_mispred_cnt
    );

    // Resolve unit side.
    modport slave (
        input  i_stall, i_if_valid, i_if_opcode, i_if_pc, i_if_prediction,
               i_if_pred_target, i_ex_taken, i_ex_target,
        output o_flush, o_redirect_valid, o_redirect_pc, o_upd_valid, o_upd_idx,
               o_upd_taken, o_upd_target, o_branch_cnt, o_mispred_cnt
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves 1-bit branch predictions in EX, issuing redirect/flush and predictor updates.
// Latency: update and redirect are registered, 1 cycle after the branch resolves in EX.
// Backpressure: i_stall freezes the shadow pipeline and resolution; FLUSH overrides the stall.
module branch_resolve_unit #(
    parameter int DATA_WIDTH   = 32,
    parameter int IDX_W        = 3,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    branch_resolve_unit_if.slave   bus
);
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic                  valid;
        logic                  is_branch;
        logic                  pred;
        logic [DATA_WIDTH-1:0] pred_target;
        logic [DATA_WIDTH-1:0] pc;
    } stage_t;

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    stage_t            if_slot;
    stage_t            id_q;
    stage_t            ex_q;
    state_t            state_q;
    state_t            state_d;
    logic [FC_W-1:0]   fcnt_q;
    logic [FC_W-1:0]   fcnt_d;
    logic              resolve;
    logic              target_wrong;
    logic              mispredict;

    logic                  upd_valid_q;
    logic [IDX_W-1:0]      upd_idx_q;
    logic                  upd_taken_q;
    logic [DATA_WIDTH-1:0] upd_target_q;
    logic                  redirect_valid_q;
    logic [DATA_WIDTH-1:0] redirect_pc_q;
    logic [CNT_W-1:0]      branch_cnt_q;
    logic [CNT_W-1:0]      mispred_cnt_q;

    // Pack the fetch slot into the shadow stage format.
    always_comb begin
        if_slot             = '0;
        if_slot.valid       = bus.i_if_valid;
        if_slot.is_branch   = (bus.i_if_opcode == OPC_BRANCH);
        if_slot.pred        = bus.i_if_prediction;
        if_slot.pred_target = bus.i_if_pred_target;
        if_slot.pc          = bus.i_if_pc;
    end

    // A not-taken branch with a stale target is still correct; target only matters when both say taken.
    assign resolve      = ex_q.valid && ex_q.is_branch && !bus.i_stall && (state_q == ST_RUN);
    assign target_wrong = bus.i_ex_taken && ex_q.pred && (bus.i_ex_target != ex_q.pred_target);
    assign mispredict   = resolve && ((bus.i_ex_taken != ex_q.pred) || target_wrong);

    // Shadow IF/ID -> ID/EX pipeline; FLUSH squashes both slots regardless of stall.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            id_q <= '0;
            ex_q <= '0;
        end else if (state_q == ST_FLUSH) begin
            id_q.valid <= 1'b0;
            ex_q.valid <= 1'b0;
        end else if (!bus.i_stall) begin
            id_q <= if_slot;
            ex_q <= id_q;
        end
    end

    // FSM state register and flush down-counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_RUN;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // FSM next state: enter FLUSH on a mispredict, leave once the counter has run down.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            ST_RUN: begin
                if (mispredict) begin
                    state_d = ST_FLUSH;
                    fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
                end
            end
            ST_FLUSH: begin
                if (fcnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    fcnt_d = fcnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
                fcnt_d  = '0;
            end
        endcase
    end

    // Registered predictor update and redirect; payloads hold between events.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            upd_valid_q      <= 1'b0;
            upd_idx_q        <= '0;
            upd_taken_q      <= 1'b0;
            upd_target_q     <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            upd_valid_q      <= resolve;
            redirect_valid_q <= mispredict;
            if (resolve) begin
                upd_idx_q    <= ex_q.pc[IDX_W+1:2];
                upd_taken_q  <= bus.i_ex_taken;
                upd_target_q <= bus.i_ex_target;
            end
            if (mispredict) begin
                redirect_pc_q <= bus.i_ex_taken ? bus.i_ex_target
                                                : ex_q.pc + DATA_WIDTH'(4);
            end
        end
    end

    // Saturating performance counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (resolve && (branch_cnt_q != {CNT_W{1'b1}})) begin
                branch_cnt_q <= branch_cnt_q + 1'b1;
            end
            if (mispredict && (mispred_cnt_q != {CNT_W{1'b1}})) begin
                mispred_cnt_q <= mispred_cnt_q + 1'b1;
            end
        end
    end

    // Flush is high for every FLUSH-state cycle, which starts alongside the redirect pulse.
    assign bus.o_flush          = (state_q == ST_FLUSH);
    assign bus.o_redirect_valid = redirect_valid_q;
    assign bus.o_redirect_pc    = redirect_pc_q;
    assign bus.o_upd_valid      = upd_valid_q;
    assign bus.o_upd_idx        = upd_idx_q;
    assign bus.o_upd_taken      = upd_taken_q;
    assign bus.o_upd_target     = upd_target_q;
    assign bus.o_branch_cnt     = branch_cnt_q;
    assign bus.o_mispred_cnt    = mispred_cnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a behavioural reference model.
// Latency: model outputs compared every cycle, 1 ns after the rising edge.
// Backpressure: exercises i_stall holding a branch in EX.
module tb_branch_resolve_unit;
    localparam int DW    = 32;
    localparam int IW    = 3;
    localparam int CW    = 4;
    localparam int FC    = 2;
    localparam int MAXC  = (1 << CW) - 1;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] ALU = 7'b0010011;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    branch_resolve_unit_if #(.DATA_WIDTH(DW), .IDX_W(IW), .CNT_W(CW)) bus ();

    branch_resolve_unit #(
        .DATA_WIDTH(DW), .IDX_W(IW), .FLUSH_CYCLES(FC), .CNT_W(CW)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit        v;
        bit        br;
        bit        pred;
        bit [31:0] pt;
        bit [31:0] pc;
    } slot_t;

    slot_t     m_id, m_ex;
    int        flush_left = 0;
    int        m_bc = 0, m_mc = 0;
    bit        e_upd_v, e_upd_taken, e_red_v;
    bit [31:0] e_upd_tgt, e_red_pc;
    int        e_upd_idx;
    bit        armed = 0;

    always @(posedge clk) begin
        bit run, res, mis;
        if (rst) begin
            m_id = '{default: 0};
            m_ex = '{default: 0};
            flush_left = 0;
            m_bc = 0; m_mc = 0;
            e_upd_v = 0; e_red_v = 0;
            armed = 1;
        end else begin
            run = (flush_left == 0);
            res = run && !bus.i_stall && m_ex.v && m_ex.br;
            mis = res && ((bus.i_ex_taken != m_ex.pred) ||
                          (bus.i_ex_taken && m_ex.pred && bus.i_ex_target != m_ex.pt));
            e_upd_v = res;
            e_red_v = mis;
            if (res) begin
                e_upd_idx   = (m_ex.pc / 4) % (1 << IW);
                e_upd_taken = bus.i_ex_taken;
                e_upd_tgt   = bus.i_ex_target;
                if (m_bc < MAXC) m_bc++;
            end
            if (mis) begin
                e_red_pc = bus.i_ex_taken ? bus.i_ex_target : m_ex.pc + 32'd4;
                if (m_mc < MAXC) m_mc++;
            end
            if (!run) begin
                m_id.v = 0;
                m_ex.v = 0;
                flush_left--;
            end else if (!bus.i_stall) begin
                m_ex = m_id;
                m_id = '{v: bus.i_if_valid, br: (bus.i_if_opcode == BR),
                         pred: bus.i_if_prediction, pt: bus.i_if_pred_target,
                         pc: bus.i_if_pc};
            end
            if (mis) flush_left = FC;
        end
        #1;
        if (armed) begin
            chk("m_flush", bus.o_flush, flush_left > 0);
            chk("m_upd_valid", bus.o_upd_valid, e_upd_v);
            chk("m_redirect_valid", bus.o_redirect_valid, e_red_v);
            if (e_upd_v) begin
                chk("m_upd_idx", bus.o_upd_idx, e_upd_idx);
                chk("m_upd_taken", bus.o_upd_taken, e_upd_taken);
                chk("m_upd_target", bus.o_upd_target, e_upd_tgt);
            end
            if (e_red_v) chk("m_redirect_pc", bus.o_redirect_pc, e_red_pc);
            chk("m_branch_cnt", bus.o_branch_cnt, m_bc);
            chk("m_mispred_cnt", bus.o_mispred_cnt, m_mc);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic idle_if();
        bus.i_if_valid = 0; bus.i_if_opcode = 7'd0; bus.i_if_pc = 0;
        bus.i_if_prediction = 0; bus.i_if_pred_target = 0;
    endtask

    // Sends one branch through an empty pipe and checks the literal outcome.
    task automatic branch_once(input logic [31:0] pc, input logic pred, input logic [31:0] pt,
                               input logic taken, input logic [31:0] tgt,
                               input logic mis, input logic [31:0] rpc, input logic [2:0] idx);
        @(negedge clk);
        bus.i_if_valid = 1; bus.i_if_opcode = BR; bus.i_if_pc = pc;
        bus.i_if_prediction = pred; bus.i_if_pred_target = pt;
        bus.i_ex_taken = taken; bus.i_ex_target = tgt;
        @(negedge clk);
        idle_if();
        @(negedge clk);
        @(negedge clk);
        chk("upd_valid", bus.o_upd_valid, 1);
        chk("upd_idx", bus.o_upd_idx, idx);
        chk("upd_taken", bus.o_upd_taken, taken);
        chk("upd_target", bus.o_upd_target, tgt);
        chk("redirect_valid", bus.o_redirect_valid, mis);
        if (mis) chk("redirect_pc", bus.o_redirect_pc, rpc);
        chk("flush_c1", bus.o_flush, mis);
        @(negedge clk);
        chk("upd_valid_pulse", bus.o_upd_valid, 0);
        chk("redirect_pulse", bus.o_redirect_valid, 0);
        chk("flush_c2", bus.o_flush, mis);
        @(negedge clk);
        chk("flush_end", bus.o_flush, 0);
    endtask

    task automatic cnt_chk(input int bc, input int mc);
        chk("branch_cnt", bus.o_branch_cnt, bc);
        chk("mispred_cnt", bus.o_mispred_cnt, mc);
    endtask

    initial begin
        rst = 1; bus.i_stall = 0; idle_if();
        bus.i_ex_taken = 0; bus.i_ex_target = 0;
        repeat (2) @(negedge clk);
        chk("rst_flush", bus.o_flush, 0);
        chk("rst_redirect_valid", bus.o_redirect_valid, 0);
        chk("rst_upd_valid", bus.o_upd_valid, 0);
        chk("rst_redirect_pc", bus.o_redirect_pc, 0);
        cnt_chk(0, 0);
        rst = 0;

        branch_once(32'h10, 0, 32'h0, 0, 32'h0, 0, 32'h0, 3'd4);
        cnt_chk(1, 0);
        branch_once(32'h20, 0, 32'h0, 1, 32'h80, 1, 32'h80, 3'd0);
        cnt_chk(2, 1);
        branch_once(32'h0C, 1, 32'h40, 1, 32'h44, 1, 32'h44, 3'd3);
        cnt_chk(3, 2);
        branch_once(32'h0C, 1, 32'h44, 1, 32'h44, 0, 32'h0, 3'd3);
        cnt_chk(4, 2);
        branch_once(32'hFFFF_FFFC, 1, 32'h100, 0, 32'h100, 1, 32'h0000_0000, 3'd7);
        cnt_chk(5, 3);
        branch_once(32'h14, 0, 32'h40, 0, 32'h48, 0, 32'h0, 3'd5);
        cnt_chk(6, 3);

        // Non-branch valid slot and invalid branch slot: nothing resolves.
        @(negedge clk);
        bus.i_if_valid = 1; bus.i_if_opcode = ALU; bus.i_if_pc = 32'h60;
        bus.i_ex_taken = 1; bus.i_ex_target = 32'h90;
        @(negedge clk);
        bus.i_if_valid = 0; bus.i_if_opcode = BR; bus.i_if_pc = 32'h64;
        @(negedge clk);
        idle_if();
        repeat (3) begin
            @(negedge clk);
            chk("nonbr_upd_valid", bus.o_upd_valid, 0);
            chk("nonbr_flush", bus.o_flush, 0);
        end
        cnt_chk(6, 3);

        // Stall with a mispredicting branch in EX, then a squashed follower.
        @(negedge clk);
        bus.i_if_valid = 1; bus.i_if_opcode = BR; bus.i_if_pc = 32'h30;
        bus.i_if_prediction = 0; bus.i_ex_taken = 1; bus.i_ex_target = 32'h200;
        @(negedge clk);
        bus.i_if_pc = 32'h34;
        @(negedge clk);
        idle_if(); bus.i_stall = 1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_upd_valid", bus.o_upd_valid, 0);
            chk("stall_redirect", bus.o_redirect_valid, 0);
        end
        bus.i_stall = 0;
        @(negedge clk);
        chk("stall_res_upd_valid", bus.o_upd_valid, 1);
        chk("stall_res_idx", bus.o_upd_idx, 3'd4);
        chk("stall_res_redirect", bus.o_redirect_valid, 1);
        chk("stall_res_pc", bus.o_redirect_pc, 32'h200);
        repeat (5) @(negedge clk);
        chk("squash_upd_valid", bus.o_upd_valid, 0);
        cnt_chk(7, 4);

        // Reset during the second flush cycle.
        @(negedge clk);
        bus.i_if_valid = 1; bus.i_if_opcode = BR; bus.i_if_pc = 32'h40;
        bus.i_if_prediction = 0; bus.i_ex_taken = 1; bus.i_ex_target = 32'h10;
        @(negedge clk);
        idle_if();
        repeat (2) @(negedge clk);
        chk("pre_rst_flush1", bus.o_flush, 1);
        @(negedge clk);
        chk("pre_rst_flush2", bus.o_flush, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("midrst_flush", bus.o_flush, 0);
        chk("midrst_redirect_valid", bus.o_redirect_valid, 0);
        chk("midrst_redirect_pc", bus.o_redirect_pc, 0);
        chk("midrst_upd_valid", bus.o_upd_valid, 0);
        chk("midrst_upd_idx", bus.o_upd_idx, 0);
        chk("midrst_upd_taken", bus.o_upd_taken, 0);
        chk("midrst_upd_target", bus.o_upd_target, 0);
        cnt_chk(0, 0);
        branch_once(32'h08, 0, 32'h0, 0, 32'h0, 0, 32'h0, 3'd2);
        cnt_chk(1, 0);

        // Saturation of both counters.
        for (int i = 0; i < 17; i++) begin
            branch_once(32'h50, 0, 32'h0, 1, 32'h60, 1, 32'h60, 3'd4);
        end
        cnt_chk(MAXC, MAXC);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
